// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing link.
// Holds the handshake mode selectors and the transmit FSM state encoding.
package cdc_pkg;

    localparam int unsigned MODE_4PHASE = 0;
    localparam int unsigned MODE_2PHASE = 1;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_REL  = 2'd2;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
// Ports:
//   clk  destination-domain clock
//   rst  asynchronous reset, active-high; clears every stage to 0
//   d    asynchronous input bit
//   q    synchronised output (last stage of the chain)
// STAGES must be at least 2.
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift chain; only the last stage is consumed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side half of a req/ack clock-domain-crossing link.
// Takes words from a local valid/ready producer, holds each on tx_data, raises
// (4-phase) or toggles (2-phase) tx_req, and waits for the synchronised ack.
// Ports:
//   clk, rst          source clock; asynchronous active-high reset
//   s_data/s_valid    word from local producer
//   s_ready           block can accept a word this cycle (combinational)
//   tx_data           registered word, stable while a transfer is pending
//   tx_req            registered request to the remote domain
//   rx_ack            acknowledge from the remote domain (asynchronous)
//   busy              transfer in progress
//   done              one-cycle pulse on transfer completion
//   xfer_cnt          completed transfers, wraps
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = MODE_4PHASE,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_req,
    input  logic              rx_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  xfer_cnt
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               tx_req_nxt;
    logic               done_nxt;
    logic               ack_s;
    logic               req_lvl;
    logic               accept;

    // rx_ack only ever reaches logic through this chain.
    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_ack),
        .q   (ack_s)
    );

    // Idle ack level: 0 for level handshake, current req level for toggle.
    assign req_lvl = (MODE == MODE_2PHASE) ? tx_req : 1'b0;

    // Holding off until ack_s settles absorbs stale or spurious acknowledges.
    assign s_ready = (state == ST_IDLE) && (ack_s == req_lvl);
    assign accept  = s_valid && s_ready;

    // Next-state and request/done generation.
    always_comb begin
        state_nxt  = state;
        tx_req_nxt = tx_req;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt  = ST_REQ;
                    tx_req_nxt = (MODE == MODE_2PHASE) ? ~tx_req : 1'b1;
                end
            end
            ST_REQ: begin
                if (MODE == MODE_2PHASE) begin
                    if (ack_s == tx_req) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end else if (ack_s) begin
                    state_nxt  = ST_REL;
                    tx_req_nxt = 1'b0;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                tx_req_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight word uncounted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx_req   <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            state  <= state_nxt;
            tx_req <= tx_req_nxt;
            done   <= done_nxt;
            busy   <= (state_nxt != ST_IDLE);
            if (done_nxt) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    // Data register is written only on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data <= '0;
        end else if (accept) begin
            tx_data <= s_data;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: three instances (4-phase/2-stage/4-bit counter,
// 2-phase/4-stage, 4-phase/4-stage), each with a remote agent on an unrelated clock.
module tb_cdc_handshake_tx;

    localparam logic [2:0] AG_MODE = 3'b010;

    logic        clk;
    logic        rclk;
    logic        rst;
    logic [2:0]  s_valid;
    logic [2:0]  s_ready;
    logic [2:0]  tx_req;
    logic [2:0]  rx_ack;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [31:0] s_data  [3];
    logic [31:0] tx_data [3];
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    logic [15:0] cnt_c;
    logic        spur_a;
    int          max_dly [3];
    logic [31:0] exp_q [3][$];

    int errors = 0;
    int checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rclk = 1'b0;
        #1;
        forever #7 rclk = ~rclk;
    end

    cdc_handshake_tx #(.DATA_W(32), .SYNC_STAGES(2), .MODE(cdc_pkg::MODE_4PHASE), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .tx_data(tx_data[0]), .tx_req(tx_req[0]), .rx_ack(rx_ack[0]), .busy(busy[0]),
        .done(done[0]), .xfer_cnt(cnt_a)
    );

    cdc_handshake_tx #(.DATA_W(32), .SYNC_STAGES(4), .MODE(cdc_pkg::MODE_2PHASE), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .tx_data(tx_data[1]), .tx_req(tx_req[1]), .rx_ack(rx_ack[1]), .busy(busy[1]),
        .done(done[1]), .xfer_cnt(cnt_b)
    );

    cdc_handshake_tx #(.DATA_W(32), .SYNC_STAGES(4), .MODE(cdc_pkg::MODE_4PHASE), .CNT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .s_data(s_data[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .tx_data(tx_data[2]), .tx_req(tx_req[2]), .rx_ack(rx_ack[2]), .busy(busy[2]),
        .done(done[2]), .xfer_cnt(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Remote agents: ack after a random delay, capture words into the scoreboard.
    for (genvar g = 0; g < 3; g++) begin : g_agent
        logic ack;
        logic pend;
        int   dly;
        int   done_n;
        int   tog_n;
        logic req_prev;

        assign rx_ack[g] = ack | ((g == 0) ? spur_a : 1'b0);

        always @(posedge rclk or posedge rst) begin
            if (rst) begin
                ack  <= 1'b0;
                pend <= 1'b0;
                dly  <= 0;
            end else if (pend) begin
                if (dly <= 0) begin
                    ack  <= tx_req[g];
                    pend <= 1'b0;
                end else begin
                    dly <= dly - 1;
                end
            end else if (tx_req[g] !== ack) begin
                if (AG_MODE[g] || tx_req[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL rx_extra%0d: observed=0x%0h expected=none", g, tx_data[g]);
                    end else begin
                        check($sformatf("rx_word%0d", g), tx_data[g], exp_q[g].pop_front());
                    end
                end
                if (max_dly[g] == 0) begin
                    ack <= tx_req[g];
                end else begin
                    pend <= 1'b1;
                    dly  <= int'($urandom_range(max_dly[g], 0));
                end
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                done_n   <= 0;
                tog_n    <= 0;
                req_prev <= 1'b0;
            end else begin
                if (done[g]) done_n <= done_n + 1;
                if (tx_req[g] !== req_prev) tog_n <= tog_n + 1;
                req_prev <= tx_req[g];
            end
        end
    end

    // One full transfer on instance A with per-transfer checks; call at a negedge.
    task automatic send_a(input logic [31:0] w, input logic [3:0] exp_cnt);
        int n;
        logic stable;
        s_data[0]  = w;
        s_valid[0] = 1'b1;
        n = 0;
        while (!s_ready[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("a_ready", 32'(s_ready[0]), 32'd1);
        check("a_req_pre", 32'(tx_req[0]), 32'd0);
        exp_q[0].push_back(w);
        @(negedge clk);
        s_valid[0] = 1'b0;
        s_data[0]  = ~w;
        check("a_req_rise", 32'(tx_req[0]), 32'd1);
        check("a_busy", 32'(busy[0]), 32'd1);
        stable = 1'b1;
        n = 0;
        while (!done[0] && n < 400) begin
            if (tx_data[0] !== w) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        check("a_done", 32'(done[0]), 32'd1);
        check("a_data_stable", 32'(stable), 32'd1);
        check("a_cnt", 32'(cnt_a), 32'(exp_cnt));
        @(negedge clk);
        check("a_done_pulse", 32'(done[0]), 32'd0);
    endtask

    // Accept-to-done latency in clk cycles for instance g; call at a negedge.
    task automatic meas(input int g, input logic [31:0] w, output int lat);
        int n;
        s_data[g]  = w;
        s_valid[g] = 1'b1;
        n = 0;
        while (!s_ready[g] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("lat_ready%0d", g), 32'(s_ready[g]), 32'd1);
        exp_q[g].push_back(w);
        @(negedge clk);
        s_valid[g] = 1'b0;
        lat = 1;
        while (!done[g] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("lat_done%0d", g), 32'(done[g]), 32'd1);
    endtask

    initial begin
        logic [31:0] saved_data;
        logic [3:0]  saved_cnt;
        int          saved_dn;
        int          n;
        int          lat;

        rst     = 1'b1;
        s_valid = '0;
        spur_a  = 1'b0;
        for (int i = 0; i < 3; i++) s_data[i] = '0;
        max_dly[0] = 5;
        max_dly[1] = 5;
        max_dly[2] = 0;
        repeat (3) @(negedge clk);

        check("rst_req", 32'(tx_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        check("rst_data_a", tx_data[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // First word, then enough transfers to wrap the 4-bit counter.
        send_a(32'hDEADBEEF, 4'd1);
        for (int i = 2; i <= 17; i++) send_a($urandom, 4'(i));

        // Spurious ack while idle must be absorbed.
        saved_data = tx_data[0];
        saved_cnt  = cnt_a;
        saved_dn   = g_agent[0].done_n;
        spur_a = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_ready_low", 32'(s_ready[0]), 32'd0);
        spur_a = 1'b0;
        repeat (5) @(negedge clk);
        check("spur_ready_back", 32'(s_ready[0]), 32'd1);
        check("spur_busy", 32'(busy[0]), 32'd0);
        check("spur_cnt", 32'(cnt_a), 32'(saved_cnt));
        check("spur_data", tx_data[0], saved_data);
        check("spur_done_n", 32'(g_agent[0].done_n), 32'(saved_dn));

        // Reset while in REQ: outputs clear immediately, word dropped.
        s_data[0]  = 32'h1234_5678;
        s_valid[0] = 1'b1;
        check("rq_ready", 32'(s_ready[0]), 32'd1);
        exp_q[0].push_back(32'h1234_5678);
        @(negedge clk);
        s_valid[0] = 1'b0;
        check("rq_in_req", 32'(tx_req[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("rq_req_clr", 32'(tx_req[0]), 32'd0);
        check("rq_busy_clr", 32'(busy[0]), 32'd0);
        check("rq_cnt_clr", 32'(cnt_a), 32'd0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rq_ready_after", 32'(s_ready[0]), 32'd1);
        send_a(32'hCAFE_F00D, 4'd1);

        // 2-phase: 100 words with s_valid held high.
        s_valid[1] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data[1] = $urandom;
            n = 0;
            while (!s_ready[1] && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("b_ready", 32'(s_ready[1]), 32'd1);
            exp_q[1].push_back(s_data[1]);
            @(negedge clk);
        end
        s_valid[1] = 1'b0;
        n = 0;
        while (cnt_b != 16'd100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("b_cnt", 32'(cnt_b), 32'd100);
        check("b_toggles", 32'(g_agent[1].tog_n), 32'd100);
        check("b_dones", 32'(g_agent[1].done_n), 32'd100);
        check("b_sb_empty", 32'(exp_q[1].size()), 32'd0);

        // Minimum latency with 4-stage sync and zero-delay agents.
        max_dly[1] = 0;
        repeat (10) @(negedge clk);
        meas(1, 32'hA5A5_0001, lat);
        check("b_lat_min5", 32'(lat >= 5), 32'd1);
        @(negedge clk);
        check("b_cnt_lat", 32'(cnt_b), 32'd101);

        meas(2, 32'h5A5A_0002, lat);
        check("c_lat_min10", 32'(lat >= 10), 32'd1);
        @(negedge clk);
        check("c_cnt", 32'(cnt_c), 32'd1);
        repeat (5) @(negedge clk);
        check("a_sb_empty", 32'(exp_q[0].size()), 32'd0);
        check("c_sb_empty", 32'(exp_q[2].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
